// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the FIFO write arbiter slice: the two-state FSM
//   encoding and the default sizing constants used by the top and rr_pick.
package fifo_arb_pkg;

  localparam int DEF_WIDTH     = 8;   // data bits per beat
  localparam int DEF_NUM_REQ   = 4;   // requesters (2..8)
  localparam int DEF_MAX_BURST = 4;   // beats per grant (1..16)

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Searches req starting at last+1,
//   wrapping modulo num_req; the first set bit wins. Because the previous
//   winner is visited last, it only wins again when it is the sole requester.
// Ports
//   req    : per-requester request vector
//   last   : index of the most recent winner
//   valid  : some request is set
//   winner : index of the selected requester (0 when !valid)
module rr_pick import fifo_arb_pkg::*; #(
  parameter int num_req = DEF_NUM_REQ
) (
  input  logic [num_req-1:0]         req,
  input  logic [$clog2(num_req)-1:0] last,
  output logic                       valid,
  output logic [$clog2(num_req)-1:0] winner
);

  localparam int IDX_W = $clog2(num_req);

  always_comb begin
    int idx;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int off = 1; off <= num_req; off++) begin
      idx = (int'(last) + off) % num_req;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Grants one of num_req writers access to a downstream FIFO for bursts of
//   up to max_burst beats, round-robin between grants. A burst ends when the
//   granted requester drops req or its last beat is accepted; if anyone else
//   (or the same requester, when alone) is still asking, the next grant is
//   issued in the same cycle so there is no idle bubble.
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   req       : per-requester write request, held while data is valid
//   req_data  : requester i data at [i*width +: width]
//   fifo_full : downstream FIFO full
//   grant     : registered one-hot grant (zero in IDLE)
//   ack       : combinational, beat taken from requester i this cycle
//   fifo_wr   : combinational FIFO write enable
//   fifo_data : combinational FIFO write data (zero in IDLE)
//   busy      : registered, high while in BURST
module fifo_write_arbiter import fifo_arb_pkg::*; #(
  parameter int width     = DEF_WIDTH,
  parameter int num_req   = DEF_NUM_REQ,
  parameter int max_burst = DEF_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [num_req-1:0]       req,
  input  logic [num_req*width-1:0] req_data,
  input  logic                     fifo_full,
  output logic [num_req-1:0]       grant,
  output logic [num_req-1:0]       ack,
  output logic                     fifo_wr,
  output logic [width-1:0]         fifo_data,
  output logic                     busy
);

  localparam int IDX_W = $clog2(num_req);
  localparam int CNT_W = $clog2(max_burst + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(max_burst - 1);

  arb_state_e         state, state_n;
  logic [IDX_W-1:0]   gidx, gidx_n;
  logic [IDX_W-1:0]   last, last_n;
  logic [CNT_W-1:0]   beat_cnt, cnt_n;
  logic [num_req-1:0] grant_n;
  logic               req_g;
  logic               accept;
  logic               burst_end;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  // In BURST, last always equals the current grant index, so a single
  // picker serves both the IDLE start and the end-of-burst handoff.
  rr_pick #(.num_req(num_req)) u_pick (
    .req    (req),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Reset gates accept so an abandoned burst writes nothing on that edge.
  always_comb begin
    req_g     = req[gidx];
    accept    = (state == BURST) && req_g && !fifo_full && !reset;
    burst_end = (state == BURST) && (!req_g || (accept && beat_cnt == LAST_BEAT));
    fifo_wr   = accept;
    ack       = accept ? grant : '0;
    fifo_data = (state == BURST) ? req_data[int'(gidx)*width +: width] : '0;
  end

  always_comb begin
    state_n = state;
    gidx_n  = gidx;
    last_n  = last;
    cnt_n   = beat_cnt;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = BURST;
          gidx_n  = pick_idx;
          last_n  = pick_idx;
          cnt_n   = '0;
        end
      end
      BURST: begin
        if (burst_end) begin
          if (pick_valid) begin
            gidx_n = pick_idx;
            last_n = pick_idx;
            cnt_n  = '0;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else if (accept) begin
          cnt_n = beat_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    grant_n = '0;
    if (state_n == BURST) grant_n[gidx_n] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gidx     <= '0;
      last     <= IDX_W'(num_req - 1);
      beat_cnt <= '0;
      grant    <= '0;
    end else begin
      state    <= state_n;
      gidx     <= gidx_n;
      last     <= last_n;
      beat_cnt <= cnt_n;
      grant    <= grant_n;
    end
  end

  assign busy = (state == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
//   Directed scenarios plus randomized traffic, each cycle compared against a
//   behavioural model of the arbitration rules kept in this bench.
module tb_fifo_write_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           fifo_full;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           fifo_wr;
  logic [W-1:0]   fifo_data;
  logic           busy;

  fifo_write_arbiter #(.width(W), .num_req(N), .max_burst(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .fifo_full (fifo_full),
    .grant     (grant),
    .ack       (ack),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: who holds the grant, how many beats they have taken,
  // and who won most recently.
  bit m_busy;
  int m_g;
  int m_last;
  int m_cnt;
  bit m_acc;

  function automatic int rr_search(input int from, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  // Inputs are applied by the caller; outputs are checked at the falling
  // edge, then the model advances to match the next rising edge.
  task automatic step();
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    int  p;
    bit  done;
    @(negedge clk);
    m_acc = m_busy && req[m_g] && !fifo_full && !reset;
    eg = '0;
    ed = '0;
    if (m_busy) begin
      eg[m_g] = 1'b1;
      ed = req_data[m_g*W +: W];
    end
    chk("grant",       32'(grant),     32'(eg));
    chk("busy",        32'(busy),      32'(m_busy));
    chk("fifo_wr",     32'(fifo_wr),   32'(m_acc));
    chk("ack",         32'(ack),       m_acc ? 32'(eg) : 32'd0);
    chk("fifo_data",   32'(fifo_data), 32'(ed));
    chk("wr_while_full", 32'(fifo_wr & fifo_full), 32'd0);
    chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);

    p = rr_search(m_last, req);
    if (reset) begin
      m_busy = 0; m_last = N - 1; m_cnt = 0;
    end else if (!m_busy) begin
      if (p >= 0) begin m_busy = 1; m_g = p; m_last = p; m_cnt = 0; end
    end else begin
      done = !req[m_g] || (m_acc && m_cnt == MB - 1);
      if (done) begin
        if (p >= 0) begin m_g = p; m_last = p; m_cnt = 0; end
        else m_busy = 0;
      end else if (m_acc) begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int nb;
    int guard;
    reset = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_busy = 0; m_last = N - 1; m_cnt = 0; m_g = 0;

    // Reset state, requests asserted while reset is held.
    req = '1;
    step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    reset = 1'b0;

    // Solo burst: data advances per accepted beat.
    req = 4'b0001;
    req_data[7:0] = 8'hA0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (m_acc) begin req_data[7:0] = req_data[7:0] + 8'd1; nb++; end
    end
    chk("solo_beats", 32'(nb), 32'd7);
    chk("solo_grant", 32'(grant), 32'b0001);

    // Round-robin with everyone requesting: 4 beats each, no gaps.
    do_reset();
    req = '1;
    step();
    for (int i = 0; i < 20; i++) begin
      chk("rr_order", 32'(grant), 32'd1 << ((i / 4) % 4));
      step();
    end

    // Backpressure in the middle of a burst.
    do_reset();
    req = 4'b0001;
    step();
    nb = 0;
    guard = 0;
    while (nb < 2 && guard < 20) begin step(); if (m_acc) nb++; guard++; end
    chk("bp_pre_beats", 32'(nb), 32'd2);
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_wr_held", 32'(fifo_wr), 32'd0);
      chk("bp_ack_held", 32'(ack), 32'd0);
      step();
    end
    fifo_full = 1'b0;
    step(); if (m_acc) nb++;
    step(); if (m_acc) nb++;
    chk("bp_total_beats", 32'(nb), 32'd4);

    // Early drop by requester 2 while requester 1 waits.
    do_reset();
    req = 4'b0100;
    step();
    chk("drop_first", 32'(grant), 32'b0100);
    req = 4'b0110;
    nb = 0;
    step(); if (m_acc) nb++;
    step(); if (m_acc) nb++;
    req = 4'b0010;
    step(); if (m_acc) nb++;
    chk("drop_beats", 32'(nb), 32'd2);
    chk("drop_regrant", 32'(grant), 32'b0010);

    // Reset in the middle of a burst.
    req = '1;
    repeat (3) step();
    do_reset();
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_busy",  32'(busy),  32'd0);
    step();
    chk("midrst_first", 32'(grant), 32'b0001);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) req = N'($urandom);
      req_data  = $urandom;
      fifo_full = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
